// File: rtl/roi_pkg.sv
// Shared ROI definitions: corner field layout, FSM states,
// normalised corner bundle and the normalise/validate helpers.
package roi_pkg;

  localparam int X_MSB = 26;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 9;
  localparam int Y_LSB = 0;
  localparam int XF_W  = X_MSB - X_LSB + 1;
  localparam int YF_W  = Y_MSB - Y_LSB + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XF_W-1:0] left;
    logic [XF_W-1:0] right;
    logic [YF_W-1:0] top;
    logic [YF_W-1:0] bottom;
  } corner_t;

  function automatic corner_t roi_norm(
    input logic [X_MSB:0] a,
    input logic [X_MSB:0] b
  );
    corner_t         c;
    logic [XF_W-1:0] xa;
    logic [XF_W-1:0] xb;
    logic [YF_W-1:0] ya;
    logic [YF_W-1:0] yb;
    xa = a[X_MSB:X_LSB];
    xb = b[X_MSB:X_LSB];
    ya = a[Y_MSB:Y_LSB];
    yb = b[Y_MSB:Y_LSB];
    c.left   = (xa < xb) ? xa : xb;
    c.right  = (xa < xb) ? xb : xa;
    c.top    = (ya < yb) ? ya : yb;
    c.bottom = (ya < yb) ? yb : ya;
    return c;
  endfunction

  // Corners are 1-based; min must be non-zero, max within the frame.
  function automatic logic roi_valid(
    input corner_t c,
    input int      w,
    input int      h
  );
    return (c.left != '0) && (c.top != '0) &&
           (int'(32'(c.right)) <= w) &&
           (int'(32'(c.bottom)) <= h);
  endfunction

endpackage

// File: rtl/roi_raster_cnt.sv
// 1-based x/y raster counter; steps once per pixel beat and
// wraps to (1,1) after (WIDTH,HEIGHT).
module roi_raster_cnt #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  localparam int XW    = $clog2(WIDTH + 1),
  localparam int YW    = $clog2(HEIGHT + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          step_i,
  input  logic          clear_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_end_o
);

  localparam logic [XW-1:0] XMAX = XW'(WIDTH);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap;

  assign x_wrap      = (x_q == XMAX);
  assign frame_end_o = x_wrap && (y_q == YMAX);
  assign x_o         = x_q;
  assign y_o         = y_q;

  // Next position: clear wins, otherwise advance on a step.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = XW'(1);
      y_d = YW'(1);
    end else if (step_i) begin
      if (x_wrap) begin
        x_d = XW'(1);
        y_d = frame_end_o ? YW'(1) : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Position registers, reset to the first pixel.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      x_q <= XW'(1);
      y_q <= YW'(1);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/roi_expand_axis.sv
// Re-expands an ROI-only pixel stream into a full raster frame,
// padding everything outside the window with FILL.
module roi_expand_axis
  import roi_pkg::*;
#(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int BIT_DATA_O = 8,
  parameter int BIT_COORD  = 32,
  parameter logic [BIT_DATA_O-1:0] FILL = '0
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  en_i,
  input  logic [BIT_COORD-1:0]  xy_0_i,
  input  logic [BIT_COORD-1:0]  xy_1_i,
  input  logic [BIT_DATA_O-1:0] tdata_i,
  input  logic                  tvalid_i,
  input  logic                  tlast_i,
  output logic                  tready_o,
  output logic [BIT_DATA_O-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tuser_o,
  output logic                  tlast_o,
  output logic                  err_o
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  state_e        state_q, state_d;
  corner_t       corner_q, corner_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          latch;
  logic          run;
  logic          in_win;
  logic          beat;
  logic          sof;
  logic          eof;
  logic          roi_end;
  logic [XW-1:0] x_w;
  logic [YW-1:0] y_w;
  logic          unused_hi;

  assign unused_hi = ^{xy_0_i[BIT_COORD-1:X_MSB+1],
                       xy_1_i[BIT_COORD-1:X_MSB+1]};

  roi_raster_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cnt (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .step_i      (beat),
    .clear_i     (~run),
    .x_o         (x_w),
    .y_o         (y_w),
    .frame_end_o (eof)
  );

  assign run = (state_q == RUN);
  assign sof = (x_w == XW'(1)) && (y_w == YW'(1));

  assign in_win = ok_q &&
    (32'(x_w) >= 32'(corner_q.left))  &&
    (32'(x_w) <= 32'(corner_q.right)) &&
    (32'(y_w) >= 32'(corner_q.top))   &&
    (32'(y_w) <= 32'(corner_q.bottom));

  assign roi_end = (32'(x_w) == 32'(corner_q.right)) &&
                   (32'(y_w) == 32'(corner_q.bottom));

  assign beat = run && tready_i && (in_win ? tvalid_i : 1'b1);

  assign err_o = err_q;

  // FSM next state, corner latch, error detect and stream muxing.
  always_comb begin
    state_d  = state_q;
    corner_d = corner_q;
    ok_d     = ok_q;
    err_d    = 1'b0;
    latch    = 1'b0;
    tvalid_o = 1'b0;
    tready_o = 1'b0;
    tdata_o  = FILL;
    tuser_o  = 1'b0;
    tlast_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          latch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        tuser_o = sof;
        tlast_o = eof;
        if (in_win) begin
          tvalid_o = tvalid_i;
          tdata_o  = tdata_i;
          tready_o = tready_i;
        end else begin
          tvalid_o = 1'b1;
        end
        if (beat && in_win && (tlast_i != roi_end)) begin
          err_d = 1'b1;
        end
        if (beat && eof) begin
          if (en_i) begin
            latch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      corner_d = roi_norm(xy_0_i[X_MSB:0], xy_1_i[X_MSB:0]);
      ok_d     = roi_valid(corner_d, WIDTH, HEIGHT);
      if (!ok_d) begin
        err_d = 1'b1;
      end
    end
  end

  // State, latched corners and the one-cycle error pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      corner_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      corner_q <= corner_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

endmodule
